// File: rtl/sar_conv_ctrl.sv
// SAR ADC conversion controller: sequences the sampling switch, enables the SAR for eight
// comparator decisions, captures the result word and hands it off with a valid/ready
// handshake. It aborts with a sticky error if the comparator stalls.
module sar_conv_ctrl #(
  parameter int unsigned SAMPLE_CYCLES = 4,
  parameter int unsigned TIMEOUT       = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       comp_op,
  input  logic       comp_om,
  input  logic [7:0] sar_d,
  input  logic       result_ready,
  output logic       sample,
  output logic       sar_en,
  output logic       busy,
  output logic [7:0] result,
  output logic       result_valid,
  output logic       timeout_err
);

  typedef enum logic [1:0] {StIdle, StSample, StConvert, StHold} state_e;

  localparam logic [3:0] SampleLoad  = 4'(SAMPLE_CYCLES);
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  state_e     state_q;
  logic [3:0] scnt_q;
  logic [3:0] bcnt_q;
  logic [7:0] tcnt_q;
  logic       decision;

  // Both comparator outputs high in one cycle still counts as a single decision.
  assign decision = comp_op | comp_om;

  // Controller FSM; all outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      scnt_q       <= '0;
      bcnt_q       <= '0;
      tcnt_q       <= '0;
      sample       <= 1'b0;
      sar_en       <= 1'b0;
      busy         <= 1'b0;
      result       <= 8'h00;
      result_valid <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q     <= StSample;
            scnt_q      <= SampleLoad;
            sample      <= 1'b1;
            busy        <= 1'b1;
            timeout_err <= 1'b0;
          end
        end
        StSample: begin
          if (scnt_q == 4'd1) begin
            state_q <= StConvert;
            sample  <= 1'b0;
            sar_en  <= 1'b1;
            bcnt_q  <= '0;
            tcnt_q  <= '0;
          end else begin
            scnt_q <= scnt_q - 4'd1;
          end
        end
        StConvert: begin
          // Once all eight bits are resolved, further decisions are ignored.
          if (bcnt_q == 4'd8) begin
            state_q      <= StHold;
            result       <= sar_d;
            result_valid <= 1'b1;
            sar_en       <= 1'b0;
          end else if (decision) begin
            bcnt_q <= bcnt_q + 4'd1;
            tcnt_q <= '0;
          end else if (tcnt_q == TimeoutLast) begin
            state_q     <= StIdle;
            sar_en      <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
            tcnt_q      <= '0;
          end else begin
            tcnt_q <= tcnt_q + 8'd1;
          end
        end
        StHold: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            // A start in the handshake cycle begins the next conversion directly.
            if (start) begin
              state_q     <= StSample;
              scnt_q      <= SampleLoad;
              sample      <= 1'b1;
              timeout_err <= 1'b0;
            end else begin
              state_q <= StIdle;
              busy    <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sar_conv_ctrl.sv
// Directed bench for sar_conv_ctrl with hand-computed expectations. Edges are counted with
// the edge that samples start as edge 1.
module tb_sar_conv_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       comp_op;
  logic       comp_om;
  logic [7:0] sar_d;
  logic       result_ready;
  logic       sample;
  logic       sar_en;
  logic       busy;
  logic [7:0] result;
  logic       result_valid;
  logic       timeout_err;

  int ncmp;
  int nerr;

  sar_conv_ctrl #(
    .SAMPLE_CYCLES(4),
    .TIMEOUT      (15)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .comp_op     (comp_op),
    .comp_om     (comp_om),
    .sar_d       (sar_d),
    .result_ready(result_ready),
    .sample      (sample),
    .sar_en      (sar_en),
    .busy        (busy),
    .result      (result),
    .result_valid(result_valid),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ncmp++;
    assert (obs === expv)
    else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Called right after the start edge (edge 1); ticks until result_valid rises or a budget
  // runs out, counting cycles with sample and sar_en high (including the one after edge 1).
  task automatic run_to_valid(output int valid_edge, output int sample_n, output int en_n);
    valid_edge = 0;
    sample_n   = sample ? 1 : 0;
    en_n       = sar_en ? 1 : 0;
    for (int e = 2; e <= 30 && valid_edge == 0; e++) begin
      tick();
      if (sample) sample_n++;
      if (sar_en) en_n++;
      if (result_valid) valid_edge = e;
    end
  endtask

  int vedge;
  int sn;
  int en;
  int n;
  int valid_seen;
  int busy_drop;

  initial begin
    ncmp = 0;
    nerr = 0;
    rst = 1'b1;
    start = 1'b1;  // start coincident with reset must be ignored
    comp_op = 1'b0;
    comp_om = 1'b0;
    sar_d = 8'h00;
    result_ready = 1'b0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sample", 32'(sample), 32'd0);
    check("rst_sar_en", 32'(sar_en), 32'd0);
    check("rst_valid", 32'(result_valid), 32'd0);
    check("rst_terr", 32'(timeout_err), 32'd0);
    check("rst_result", 32'(result), 32'h00);
    rst = 1'b0;
    start = 1'b0;
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    // Nominal conversion.
    sar_d = 8'hFF;
    comp_op = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("nom_sample_rise", 32'(sample), 32'd1);
    check("nom_busy", 32'(busy), 32'd1);
    run_to_valid(vedge, sn, en);
    check("nom_valid_edge", 32'(vedge), 32'd14);
    check("nom_sample_cycles", 32'(sn), 32'd4);
    check("nom_sar_en_cycles", 32'(en), 32'd9);
    check("nom_result", 32'(result), 32'hFF);
    check("nom_hold_sar_en", 32'(sar_en), 32'd0);

    // Backpressure: result held, start ignored.
    sar_d = 8'h00;
    for (int i = 0; i < 20; i++) begin
      start = i[0];
      tick();
      check("bp_result", 32'(result), 32'hFF);
      check("bp_valid", 32'(result_valid), 32'd1);
      check("bp_sample", 32'(sample), 32'd0);
    end
    start = 1'b0;
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check("bp_release_valid", 32'(result_valid), 32'd0);
    check("bp_release_busy", 32'(busy), 32'd0);
    check("bp_release_result", 32'(result), 32'hFF);

    // Timeout: 3 decisions then silence.
    comp_op = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("to_sar_en", 32'(sar_en), 32'd1);
    comp_op = 1'b1;
    repeat (3) tick();
    comp_op = 1'b0;
    n = 0;
    valid_seen = 0;
    while (busy && n < 40) begin
      tick();
      n++;
      if (result_valid) valid_seen = 1;
    end
    check("to_idle_cycles", 32'(n), 32'd15);
    check("to_err", 32'(timeout_err), 32'd1);
    check("to_sar_en_off", 32'(sar_en), 32'd0);
    check("to_valid_never", 32'(valid_seen), 32'd0);
    check("to_result_kept", 32'(result), 32'hFF);
    repeat (3) tick();
    check("to_err_sticky", 32'(timeout_err), 32'd1);

    // Sparse decisions every 14 cycles: the new start clears the error.
    sar_d = 8'h5A;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("sp_err_cleared", 32'(timeout_err), 32'd0);
    repeat (4) tick();
    busy_drop = 0;
    for (int k = 0; k < 8; k++) begin
      comp_op = 1'b0;
      repeat (13) begin
        tick();
        if (!busy) busy_drop = 1;
      end
      comp_op = 1'b1;
      tick();
    end
    comp_op = 1'b0;
    tick();
    check("sp_no_abort", 32'(busy_drop), 32'd0);
    check("sp_valid", 32'(result_valid), 32'd1);
    check("sp_result", 32'(result), 32'h5A);
    check("sp_err", 32'(timeout_err), 32'd0);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;

    // Reset mid-CONVERT after 5 decisions.
    comp_op = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    comp_op = 1'b0;
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_sar_en", 32'(sar_en), 32'd0);
    check("mr_sample", 32'(sample), 32'd0);
    check("mr_valid", 32'(result_valid), 32'd0);
    check("mr_result", 32'(result), 32'h00);

    // Fresh conversion using the negative-decision input.
    sar_d = 8'hC3;
    comp_om = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    run_to_valid(vedge, sn, en);
    check("fr_valid_edge", 32'(vedge), 32'd14);
    check("fr_result", 32'(result), 32'hC3);

    // Back-to-back with both comparator outputs high (one decision per cycle).
    result_ready = 1'b1;
    start = 1'b1;
    tick();
    result_ready = 1'b0;
    start = 1'b0;
    check("bb_sample", 32'(sample), 32'd1);
    check("bb_valid_drop", 32'(result_valid), 32'd0);
    check("bb_busy", 32'(busy), 32'd1);
    sar_d = 8'h3C;
    comp_op = 1'b1;
    run_to_valid(vedge, sn, en);
    check("bb_valid_edge", 32'(vedge), 32'd14);
    check("bb_sar_en_cycles", 32'(en), 32'd9);
    check("bb_result", 32'(result), 32'h3C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
